// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer: FSM state encoding and default counter width.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int DEFAULT_CTR_W = 32;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; tc flags the terminal count.
module seq_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/run_sequencer.sv
// Drives a worker's reset/go: stretched reset, a RUN_CYCLES-long run window, then a done pulse.
//   state | meaning
//   IDLE  | worker held in reset, waiting for start
//   HOLD  | reset stretched for HOLD_CYCLES after start
//   RUN   | go high, ctr counts elapsed run cycles
//   DONE  | single cycle, run window finished normally
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int RUN_CYCLES  = 10,
  parameter int CTR_W       = DEFAULT_CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             dut_rst,
  output logic             go,
  output logic             busy,
  output logic [CTR_W-1:0] ctr,
  output logic             done,
  output logic             aborted
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0]  RUN_LAST  = CTR_W'(RUN_CYCLES - 1);

  // RUN_CYCLES is an int, so any CTR_W >= 31 can always hold it.
  if (HOLD_CYCLES < 1 || RUN_CYCLES < 1 ||
      (CTR_W < 31 && RUN_CYCLES >= (1 << CTR_W))) begin : g_param_check
    $error("run_sequencer: illegal HOLD_CYCLES/RUN_CYCLES/CTR_W combination");
  end

  seq_state_t state;
  logic       hold_load;
  logic       hold_en;
  logic       hold_tc;

  // Counter is reloaded throughout IDLE so it is primed the moment HOLD begins.
  assign hold_load = (state == IDLE);
  assign hold_en   = (state == HOLD);

  seq_down_counter #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (hold_en),
    .tc       (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dut_rst <= 1'b1;
      go      <= 1'b0;
      busy    <= 1'b0;
      ctr     <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= HOLD;
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (hold_tc) begin
            state   <= RUN;
            dut_rst <= 1'b0;
            go      <= 1'b1;
            ctr     <= '0;
          end
        end
        RUN: begin
          // Abort outranks completion in the final run cycle.
          if (abort) begin
            state   <= IDLE;
            dut_rst <= 1'b1;
            go      <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (ctr == RUN_LAST) begin
            state   <= DONE;
            dut_rst <= 1'b1;
            go      <= 1'b0;
            done    <= 1'b1;
            ctr     <= ctr + CTR_W'(1);
          end else begin
            ctr <= ctr + CTR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          dut_rst <= 1'b1;
          go      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench: default sequencer (4/10) plus a minimal 1/1 instance for the boundary case.
module tb_run_sequencer;

  logic        clk;
  logic        a_rst, a_start, a_abort;
  logic        a_dut_rst, a_go, a_busy, a_done, a_aborted;
  logic [31:0] a_ctr;
  logic        b_rst, b_start, b_abort;
  logic        b_dut_rst, b_go, b_busy, b_done, b_aborted;
  logic [3:0]  b_ctr;

  int checks;
  int failures;

  // Expected {dut_rst, go, busy, done, aborted}
  localparam logic [4:0] V_IDLE = 5'b10000;
  localparam logic [4:0] V_HOLD = 5'b10100;
  localparam logic [4:0] V_RUN  = 5'b01100;
  localparam logic [4:0] V_DONE = 5'b10110;
  localparam logic [4:0] V_ABRT = 5'b10001;

  run_sequencer #(.HOLD_CYCLES(4), .RUN_CYCLES(10), .CTR_W(32)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
    .dut_rst(a_dut_rst), .go(a_go), .busy(a_busy), .ctr(a_ctr),
    .done(a_done), .aborted(a_aborted)
  );

  run_sequencer #(.HOLD_CYCLES(1), .RUN_CYCLES(1), .CTR_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .dut_rst(b_dut_rst), .go(b_go), .busy(b_busy), .ctr(b_ctr),
    .done(b_done), .aborted(b_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [4:0] vec_obs, input logic [4:0] vec_exp,
                     input logic [31:0] ctr_obs, input logic [31:0] ctr_exp);
    checks++;
    assert ({vec_obs, ctr_obs} === {vec_exp, ctr_exp}) else begin
      failures++;
      $error("FAIL %s observed flags=%b ctr=%0d expected flags=%b ctr=%0d",
             tag, vec_obs, ctr_obs, vec_exp, ctr_exp);
    end
  endtask

  function automatic logic [4:0] va();
    return {a_dut_rst, a_go, a_busy, a_done, a_aborted};
  endfunction

  function automatic logic [4:0] vb();
    return {b_dut_rst, b_go, b_busy, b_done, b_aborted};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_a", va(), V_IDLE, a_ctr, 32'd0);
    chk("reset_b", vb(), V_IDLE, 32'(b_ctr), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("idle_after_reset", va(), V_IDLE, a_ctr, 32'd0);

    // Full normal sequence
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t1_hold0", va(), V_HOLD, a_ctr, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_hold", va(), V_HOLD, a_ctr, 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_run", va(), V_RUN, a_ctr, 32'(k));
    end
    tick();
    chk("t1_done", va(), V_DONE, a_ctr, 32'd10);
    tick();
    chk("t1_idle", va(), V_IDLE, a_ctr, 32'd10);
    tick();
    chk("t1_idle_hold_ctr", va(), V_IDLE, a_ctr, 32'd10);

    // Abort in the third run cycle
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t2_hold0", va(), V_HOLD, a_ctr, 32'd10);
    for (int i = 1; i < 4; i++) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_run", va(), V_RUN, a_ctr, 32'(k));
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("t2_aborted", va(), V_ABRT, a_ctr, 32'd2);
    tick();
    chk("t2_idle_after", va(), V_IDLE, a_ctr, 32'd2);

    // Start and abort together in IDLE
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    a_start = 1'b0; a_abort = 1'b0;
    chk("t4_start_abort", va(), V_IDLE, a_ctr, 32'd2);
    tick();
    chk("t4_still_idle", va(), V_IDLE, a_ctr, 32'd2);

    // Start held high: one sequence, then immediate restart from IDLE
    a_start = 1'b1;
    tick();
    chk("t3_hold0", va(), V_HOLD, a_ctr, 32'd2);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t3_hold", va(), V_HOLD, a_ctr, 32'd2);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_run", va(), V_RUN, a_ctr, 32'(k));
    end
    tick();
    chk("t3_done", va(), V_DONE, a_ctr, 32'd10);
    tick();
    chk("t3_idle_between", va(), V_IDLE, a_ctr, 32'd10);
    tick();
    a_start = 1'b0;
    chk("t3_restart_hold", va(), V_HOLD, a_ctr, 32'd10);
    for (int i = 1; i < 4; i++) tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3_run2", va(), V_RUN, a_ctr, 32'(k));
    end

    // Synchronous reset during RUN at ctr=5
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("t5_reset_in_run", va(), V_IDLE, a_ctr, 32'd0);
    tick();
    chk("t5_idle_after", va(), V_IDLE, a_ctr, 32'd0);

    // Abort during HOLD
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    chk("hold_abort_pre", va(), V_HOLD, a_ctr, 32'd0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("hold_abort", va(), V_ABRT, a_ctr, 32'd0);

    // Minimal HOLD=1 RUN=1 instance
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("t6_hold", vb(), V_HOLD, 32'(b_ctr), 32'd0);
    tick();
    chk("t6_run", vb(), V_RUN, 32'(b_ctr), 32'd0);
    tick();
    chk("t6_done", vb(), V_DONE, 32'(b_ctr), 32'd1);
    tick();
    chk("t6_idle", vb(), V_IDLE, 32'(b_ctr), 32'd1);

    // Abort on the final RUN cycle of the minimal instance: abort wins
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    chk("t6_run_again", vb(), V_RUN, 32'(b_ctr), 32'd0);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    chk("t6_abort_last", vb(), V_ABRT, 32'(b_ctr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream control stage that drives the reset/go input of a simulation-paced worker block.
- The worker spins while its go input is low, then runs a fixed number of clock cycles.
- This block issues a stretched reset, opens a run window of exactly RUN_CYCLES clocks, and reports completion.
- Supports start/abort handshakes and exposes an elapsed-cycle counter for $display-style monitoring.

Parameters:
- HOLD_CYCLES, 4: cycles dut_rst stays asserted after a start is accepted; legal range is 1 or more.
- RUN_CYCLES, 10: length of the run window in cycles; legal range is 1 or more.
- CTR_W, 32: width of the cycle counter; must satisfy 2^CTR_W > RUN_CYCLES.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
- abort  input  1  terminates HOLD or RUN; ignored in IDLE and DONE.
- dut_rst  output  1  active-high reset to downstream worker.
- go  output  1  level, high only during RUN (downstream "proceed").
- busy  output  1  high in HOLD, RUN, DONE.
- ctr  output  CTR_W  cycles elapsed in current/last run.
- done  output  1  one-cycle pulse when the run window completes normally.
- aborted  output  1  one-cycle pulse when abort terminates a sequence.

Behaviour:
- Reset is sampled at posedge. Reset values: state=IDLE, dut_rst=1, go=0, busy=0, ctr=0, done=0, aborted=0.
- Reset mid-sequence: same reset values on the next edge; no done or aborted pulse is issued.
- States are IDLE, HOLD, RUN, DONE. All outputs are registered and decoded from state.
- IDLE:
  - dut_rst=1, go=0; ctr holds its last value.
  - start=1 at edge t moves to HOLD at t+1 and clears the hold counter.
- HOLD:
  - dut_rst=1, busy=1.
  - Stays exactly HOLD_CYCLES cycles (t+1 .. t+HOLD_CYCLES), then RUN.
  - ctr is cleared to 0 on the HOLD->RUN transition.
- RUN:
  - dut_rst=0, go=1.
  - ctr=k in the k-th RUN cycle, k=0..RUN_CYCLES-1, incrementing by 1 per cycle.
  - After RUN_CYCLES cycles, moves to DONE.
- DONE:
  - Lasts one cycle: go=0, dut_rst=1, done=1, ctr=RUN_CYCLES.
  - Then IDLE; ctr holds RUN_CYCLES until the next run starts.
- Abort:
  - abort=1 in HOLD or RUN moves to IDLE on the next edge, with aborted=1 for that single IDLE cycle.
  - done is not pulsed; ctr freezes at its value from the abort cycle.
- Simultaneous events:
  - start and abort together in IDLE: stay IDLE; nothing is pulsed.
  - abort in the last RUN cycle: abort wins (goes to IDLE with aborted=1, no done).
  - start while busy is dropped; it is not queued.
  - start in the cycle after done (IDLE) is accepted normally; back-to-back sequences are allowed.
- Arithmetic:
  - The hold counter is $clog2(HOLD_CYCLES+1) bits; ctr is CTR_W bits.
  - Neither counter wraps inside a legal parameter set.
  - Elaboration-time check fails if RUN_CYCLES >= 2^CTR_W, RUN_CYCLES == 0, or HOLD_CYCLES == 0.
- Sequence latency: start edge to first go=1 cycle is HOLD_CYCLES+1 cycles; start edge to done is HOLD_CYCLES+RUN_CYCLES+1 cycles.

Decomposition:
- Shared package run_seq_pkg holds:
  - the state enum (IDLE=0, HOLD=1, RUN=2, DONE=3);
  - a localparam default CTR_W=32.
- One natural sub-module: seq_down_counter, a loadable terminal-count counter used for the HOLD phase.
- RUN counting stays inline, because ctr is an exported value.

Test Plan:
1. Reset, then start pulse at cycle 5 -> dut_rst=1 through cycle 9; go=1 on cycles 10..19 with ctr 0..9; done=1 and ctr=10 at cycle 20; IDLE with dut_rst=1 at cycle 21.
2. abort at the 3rd RUN cycle (ctr=2) -> IDLE next cycle, aborted=1 for one cycle, done never asserts, ctr stays 2.
3. start held high for 30 cycles -> exactly one sequence runs; a second sequence starts at the cycle after done (start re-sampled in IDLE).
4. start and abort in the same IDLE cycle -> no state change, busy=0, no pulses.
5. rst asserted during RUN at ctr=5 -> next cycle dut_rst=1, go=0, ctr=0, done=0, aborted=0.
6. HOLD_CYCLES=1, RUN_CYCLES=1 -> start at t gives go=1 only at t+2 with ctr=0, and done at t+3 with ctr=1.
